// File: rtl/fir_decim_out.sv
// fir_decim_out: integrate-and-dump decimator for the fir_filter output.
// Sums D accepted samples, rounds half toward +inf, shifts right by SHIFT,
// saturates to WIDTH_O and queues the result in a first-word-fall-through
// FIFO with a valid/ready output. A full FIFO discards results (sticky drop)
// instead of stalling the filter.
// Optional feature: define FIR_DECIM_SAT_COUNT_EN to build the 16-bit
// saturation event counter; otherwise sat_count is tied to zero.
module fir_decim_out #(
    parameter int WIDTH_Y = 8,
    parameter int D       = 4,
    parameter int SHIFT   = 2,
    parameter int WIDTH_O = 8,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic signed [WIDTH_Y-1:0]   y,
    input  logic                        in_valid,
    output logic signed [WIDTH_O-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        drop,
    output logic                        sat,
    output logic [15:0]                 sat_count
);

    localparam int AW   = WIDTH_Y + $clog2(D);
    localparam int AWR  = AW + 1;
    localparam int EW   = ((AWR > WIDTH_O) ? AWR : WIDTH_O) + 1;
    localparam int PW   = (D > 1) ? $clog2(D) : 1;
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    localparam int RS   = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [PW-1:0]          LAST_PHASE = PW'(D - 1);
    localparam logic [CW-1:0]          FULL       = CW'(DEPTH);
    localparam logic signed [EW-1:0]   O_MAX = {{(EW-WIDTH_O+1){1'b0}}, {(WIDTH_O-1){1'b1}}};
    localparam logic signed [EW-1:0]   O_MIN = {{(EW-WIDTH_O+1){1'b1}}, {(WIDTH_O-1){1'b0}}};

    logic signed [AW-1:0]      acc;
    logic signed [AW-1:0]      y_ext;
    logic signed [AW-1:0]      sum;
    logic [PW-1:0]             phase;
    logic signed [AWR-1:0]     rnd_const;
    logic signed [AWR-1:0]     rnd_sum;
    logic signed [AWR-1:0]     rnd_sh;
    logic signed [EW-1:0]      scaled;
    logic signed [WIDTH_O-1:0] result;
    logic                      clamp;
    logic                      dump;
    logic                      push;
    logic                      pop;

    logic signed [WIDTH_O-1:0] mem [DEPTH];
    logic [PTRW-1:0]           wr_ptr;
    logic [PTRW-1:0]           rd_ptr;
    logic [PTRW-1:0]           rd_next;
    logic [CW-1:0]             count;
    logic [CW-1:0]             count_next;
    logic signed [WIDTH_O-1:0] head;
    logic signed [WIDTH_O-1:0] head_next;

    // Dump arithmetic: widen by one bit so the rounding offset cannot wrap,
    // then compare against the output range in a width that holds both.
    always_comb begin
        y_ext     = AW'(y);
        sum       = acc + y_ext;
        rnd_const = '0;
        if (SHIFT > 0) begin
            rnd_const[RS] = 1'b1;
        end
        rnd_sum = AWR'(sum) + rnd_const;
        rnd_sh  = rnd_sum >>> SHIFT;
        scaled  = EW'(rnd_sh);
        clamp   = 1'b0;
        result  = scaled[WIDTH_O-1:0];
        if (scaled > O_MAX) begin
            clamp  = 1'b1;
            result = O_MAX[WIDTH_O-1:0];
        end else if (scaled < O_MIN) begin
            clamp  = 1'b1;
            result = O_MIN[WIDTH_O-1:0];
        end
    end

    // FIFO control; the head register is reloaded with whichever entry will
    // be at the front after this edge, bypassing a result written this edge.
    always_comb begin
        dump       = in_valid && (phase == LAST_PHASE);
        pop        = (count != '0) && out_ready;
        push       = dump && ((count != FULL) || pop);
        rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
        head_next = head;
        if (count_next != '0) begin
            if (push && (wr_ptr == rd_next)) begin
                head_next = result;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Accumulator and phase advance only on accepted samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc   <= '0;
            phase <= '0;
        end else if (in_valid) begin
            if (phase == LAST_PHASE) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + 1'b1;
            end
        end
    end

    // Storage array without reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result;
        end
    end

    // FIFO pointers, occupancy and the registered head of queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            head   <= head_next;
        end
    end

    // Sticky status flags; a dropped dump still reports its saturation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop <= 1'b0;
            sat  <= 1'b0;
        end else begin
            if (dump && !push) begin
                drop <= 1'b1;
            end
            if (dump && clamp) begin
                sat <= 1'b1;
            end
        end
    end

`ifdef FIR_DECIM_SAT_COUNT_EN
    logic [15:0] sat_cnt;

    // Saturating count of saturating dumps, dropped ones included.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_cnt <= '0;
        end else if (dump && clamp && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign sat_count = sat_cnt;
`else
    assign sat_count = 16'h0000;
`endif

    assign out_data  = head;
    assign out_valid = (count != '0);
    assign level     = count;

endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: two instances (SHIFT=2 and SHIFT=0) share one directed
// stimulus stream. Each has a queue-based reference model checked every
// cycle, and directed steps add hand-computed literal expectations.
module tb_fir_decim_out;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic              clk       = 1'b0;
    logic              rstn      = 1'b1;
    logic signed [7:0] y         = '0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;

    logic signed [7:0] od [2];
    logic              ov [2];
    logic [2:0]        lv [2];
    logic              dr [2];
    logic              st [2];
    logic [15:0]       sc [2];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FIR_DECIM_SAT_COUNT_EN
    localparam int SATC_T3 = 2;
`else
    localparam int SATC_T3 = 0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // floor((s + half) / 2^sh) with explicit floor for negative numerators
    function automatic int round_shift(input int s, input int sh);
        int div;
        int num;
        int q;
        div = 1 << sh;
        num = s + ((sh > 0) ? div / 2 : 0);
        q   = num / div;
        if ((num % div != 0) && (num < 0)) begin
            q = q - 1;
        end
        return q;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_inst
            localparam int SH = (gi == 0) ? 2 : 0;

            fir_decim_out #(
                .WIDTH_Y(8), .D(D), .SHIFT(SH), .WIDTH_O(8), .DEPTH(DEPTH)
            ) u_dut (
                .clk(clk), .rstn(rstn), .y(y), .in_valid(in_valid),
                .out_data(od[gi]), .out_valid(ov[gi]), .out_ready(out_ready),
                .level(lv[gi]), .drop(dr[gi]), .sat(st[gi]), .sat_count(sc[gi])
            );

            int q[$];
            int acc_m  = 0;
            int n_m    = 0;
            int shown  = 0;
            int satc_m = 0;
            bit drop_m = 1'b0;
            bit sat_m  = 1'b0;

            // reference model: list of collected samples and a bounded queue
            always @(posedge clk or negedge rstn) begin
                int r;
                if (!rstn) begin
                    q.delete();
                    acc_m  = 0;
                    n_m    = 0;
                    shown  = 0;
                    satc_m = 0;
                    drop_m = 1'b0;
                    sat_m  = 1'b0;
                end else begin
                    if ((q.size() > 0) && out_ready) begin
                        void'(q.pop_front());
                    end
                    if (in_valid) begin
                        acc_m += int'(y);
                        n_m++;
                        if (n_m == D) begin
                            r = round_shift(acc_m, SH);
                            if (r > 127 || r < -128) begin
                                sat_m = 1'b1;
`ifdef FIR_DECIM_SAT_COUNT_EN
                                if (satc_m < 65535) satc_m++;
`endif
                                r = (r > 127) ? 127 : -128;
                            end
                            if (q.size() < DEPTH) q.push_back(r);
                            else drop_m = 1'b1;
                            acc_m = 0;
                            n_m   = 0;
                        end
                    end
                    if (q.size() > 0) shown = q[0];
                end
            end

            // per-cycle comparison of every output against the model
            always @(negedge clk) begin
                chk($sformatf("i%0d out_valid", gi), ov[gi], (q.size() > 0));
                chk($sformatf("i%0d level", gi), lv[gi], q.size());
                chk($sformatf("i%0d out_data", gi), od[gi], shown);
                chk($sformatf("i%0d drop", gi), dr[gi], drop_m);
                chk($sformatf("i%0d sat", gi), st[gi], sat_m);
                chk($sformatf("i%0d sat_count", gi), sc[gi], satc_m);
            end
        end
    endgenerate

    task automatic feed(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            y        = 8'(v);
            in_valid = 1'b1;
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #1 rstn = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", ov[0], 0);
        chk("reset out_data", od[0], 0);
        chk("reset level", lv[0], 0);
        chk("reset sat_count", sc[1], 0);
        rstn = 1'b1;

        // 1: 1+2+3+4=10 -> (10+2)>>>2 = 3, one cycle after the 4th sample
        for (int v = 1; v <= 4; v++) begin
            @(negedge clk);
            y        = 8'(v);
            in_valid = 1'b1;
        end
        chk("t1 not yet valid", ov[0], 0);
        go_idle();
        chk("t1 out_valid", ov[0], 1);
        chk("t1 out_data", od[0], 3);
        chk("t1 raw sum", od[1], 10);
        @(negedge clk);
        chk("t1 popped", ov[0], 0);
        chk("t1 data held", od[0], 3);

        // 2: -10 -> (-10+2)>>>2 = -2
        feed(-3, 2);
        feed(-2, 2);
        go_idle();
        chk("t2 out_data", od[0], -2);
        chk("t2 raw sum", od[1], -10);
        chk("t2 sat", st[0], 0);

        // 3: SHIFT=0 instance clamps 400 and -512
        feed(100, 4);
        go_idle();
        chk("t3 clamp high", od[1], 127);
        chk("t3 sat set", st[1], 1);
        chk("t3 shift2 value", od[0], 100);
        chk("t3 shift2 sat", st[0], 0);
        feed(-128, 4);
        go_idle();
        chk("t3 clamp low", od[1], -128);
        chk("t3 shift2 low", od[0], -128);
        chk("t3 sat_count", sc[1], SATC_T3);
        chk("t3 shift2 sat_count", sc[0], 0);

        // 4: five dumps into a 4-deep FIFO with the consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) feed(k, 4);
        go_idle();
        chk("t4 level full", lv[0], 4);
        chk("t4 drop", dr[0], 1);
        for (int k = 1; k <= 4; k++) begin
            chk("t4 drain order", od[0], k);
            out_ready = 1'b1;
            @(negedge clk);
        end
        chk("t4 level empty", lv[0], 0);

        // 5: push and pop on the same edge while full
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) feed(k, 4);
        feed(5, 3);
        @(negedge clk);
        y         = 8'sd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        go_idle();
        chk("t5 level stays", lv[0], 4);
        chk("t5 no drop", dr[0], 0);
        for (int k = 2; k <= 5; k++) begin
            chk("t5 order", od[0], k);
            @(negedge clk);
        end
        chk("t5 level empty", lv[0], 0);

        // 6: asynchronous reset mid-group with FIFO contents
        do_reset();
        out_ready = 1'b0;
        feed(3, 4);
        go_idle();
        chk("t6 pre valid", ov[0], 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            y        = 8'sd7;
            in_valid = (i % 2 == 0);
        end
        #2 rstn = 1'b0;
        #1;
        chk("t6 async out_valid", ov[0], 0);
        chk("t6 async out_data", od[0], 0);
        chk("t6 async level", lv[0], 0);
        chk("t6 async sat", st[1], 0);
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        feed(4, 4);
        go_idle();
        chk("t6 fresh sum", od[0], 4);
        chk("t6 fresh raw", od[1], 16);
        chk("t6 fresh valid", ov[0], 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
